// File: rtl/proc_dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_dmem_pkg
//  Description : Shared types and constants for the M-stage data-memory
//                adapter. The state enum encodes the adapter FSM; the request
//                type constants are shared with the processor control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   localparam logic DMEM_READ  = 1'b0;
   localparam logic DMEM_WRITE = 1'b1;

endpackage : proc_dmem_pkg
`default_nettype wire

// File: rtl/proc_dmem_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module      : proc_dmem_adapter_if
//  Description : Multi-cycle valid/ready data-memory port.
//                master : adapter side (drives the request, takes responses)
//                slave  : memory side (accepts requests, drives responses)
//                mem_req_val/rdy/type/addr/wdata : request channel
//                mem_resp_val/rdata              : response channel (no rdy;
//                                                  the adapter always accepts)
//  Revision    : 1.0  initial release
// ============================================================================
interface proc_dmem_adapter_if #(
   parameter int p_addr_nbits = 32,
   parameter int p_data_nbits = 32
) ();

   logic                    mem_req_val;
   logic                    mem_req_rdy;
   logic                    mem_req_type;
   logic [p_addr_nbits-1:0] mem_req_addr;
   logic [p_data_nbits-1:0] mem_req_wdata;
   logic                    mem_resp_val;
   logic [p_data_nbits-1:0] mem_resp_rdata;

   modport master (
      output mem_req_val,
      output mem_req_type,
      output mem_req_addr,
      output mem_req_wdata,
      input  mem_req_rdy,
      input  mem_resp_val,
      input  mem_resp_rdata
   );

   modport slave (
      input  mem_req_val,
      input  mem_req_type,
      input  mem_req_addr,
      input  mem_req_wdata,
      output mem_req_rdy,
      output mem_resp_val,
      output mem_resp_rdata
   );

endinterface : proc_dmem_adapter_if
`default_nettype wire

// File: rtl/proc_dmem_adapter_register.sv
`default_nettype none
// ============================================================================
//  Module      : Register
//  Description : Enabled register with synchronous active-high reset to zero.
//                clk, rst : clock / synchronous reset
//                en       : load enable
//                d        : next value, loaded when en is high
//                q        : stored value
//  Revision    : 1.0  initial release
// ============================================================================
module Register #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : Register
`default_nettype wire

// File: rtl/proc_dmem_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : proc_dmem_adapter
//  Description : Bridges the single-cycle M-stage data-memory request of the
//                five-stage pipeline to a multi-cycle valid/ready memory port
//                and raises stall_M while a transaction is outstanding.
//  Ports       : clk, rst              clock, synchronous active-high reset
//                dmemreq_val/type/addr/wdata  M-stage request
//                dmemresp_rdata        load data (valid in the DONE cycle)
//                stall_M               pipeline hold to the control unit
//                err_unexp_resp        sticky: response seen outside WAIT
//                err_misaligned        sticky: misaligned request (optional)
//                mem                   memory port (master modport)
//  Options     : PROC_DMEM_ADAPTER_ALIGN_CHECK_EN -- when defined, requests
//                with addr[1:0] != 0 complete locally without touching memory
//                (reads return 0) and set err_misaligned.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_dmem_adapter
   import proc_dmem_pkg::*;
#(
   parameter int p_addr_nbits = 32,
   parameter int p_data_nbits = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dmemreq_val,
   input  logic                    dmemreq_type,
   input  logic [p_addr_nbits-1:0] dmemreq_addr,
   input  logic [p_data_nbits-1:0] dmemreq_wdata,
   output logic [p_data_nbits-1:0] dmemresp_rdata,
   output logic                    stall_M,
   output logic                    err_unexp_resp,
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
   output logic                    err_misaligned,
`endif
   proc_dmem_adapter_if.master     mem
);

   dmem_state_t             state_q;
   dmem_state_t             state_d;
   logic                    req_en;
   logic                    rdata_en;
   logic [p_data_nbits-1:0] rdata_d;
   logic                    req_type_q;
   logic [p_addr_nbits-1:0] req_addr_q;
   logic [p_data_nbits-1:0] req_wdata_q;
   logic                    err_unexp_q;
   logic                    err_unexp_d;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
   logic                    err_mis_q;
   logic                    err_mis_d;
`endif

   // ------------------------------------------------------------------------
   // FSM next-state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      req_en          = 1'b0;
      rdata_en        = 1'b0;
      rdata_d         = mem.mem_resp_rdata;
      stall_M         = 1'b0;
      mem.mem_req_val = 1'b0;
      err_unexp_d     = err_unexp_q;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
      err_mis_d       = err_mis_q;
`endif

      case (state_q)
         IDLE: begin
            if (dmemreq_val) begin
               stall_M = 1'b1;
               req_en  = 1'b1;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
               // Misaligned accesses never reach memory: complete next cycle.
               if (dmemreq_addr[1:0] != 2'b00) begin
                  state_d   = DONE;
                  err_mis_d = 1'b1;
                  if (dmemreq_type == DMEM_READ) begin
                     rdata_en = 1'b1;
                     rdata_d  = '0;
                  end
               end else begin
                  state_d = REQ;
               end
`else
               state_d = REQ;
`endif
            end
         end
         REQ: begin
            stall_M         = 1'b1;
            mem.mem_req_val = 1'b1;
            if (mem.mem_req_rdy) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            stall_M = 1'b1;
            if (mem.mem_resp_val) begin
               state_d = DONE;
               // Write responses carry no data; keep the previous load value.
               if (req_type_q == DMEM_READ) begin
                  rdata_en = 1'b1;
               end
            end
         end
         DONE: begin
            // The pipeline advances this cycle, so no stall and no capture.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Responses are only expected in WAIT; anything else is latched as an
      // error and otherwise ignored.
      if (mem.mem_resp_val && (state_q != WAIT)) begin
         err_unexp_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         err_unexp_q <= 1'b0;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
         err_mis_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         err_unexp_q <= err_unexp_d;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
         err_mis_q   <= err_mis_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Request and load-data registers
   // ------------------------------------------------------------------------
   Register #(.WIDTH(1)) u_req_type (
      .clk (clk),
      .rst (rst),
      .en  (req_en),
      .d   (dmemreq_type),
      .q   (req_type_q)
   );

   Register #(.WIDTH(p_addr_nbits)) u_req_addr (
      .clk (clk),
      .rst (rst),
      .en  (req_en),
      .d   (dmemreq_addr),
      .q   (req_addr_q)
   );

   Register #(.WIDTH(p_data_nbits)) u_req_wdata (
      .clk (clk),
      .rst (rst),
      .en  (req_en),
      .d   (dmemreq_wdata),
      .q   (req_wdata_q)
   );

   Register #(.WIDTH(p_data_nbits)) u_rdata (
      .clk (clk),
      .rst (rst),
      .en  (rdata_en),
      .d   (rdata_d),
      .q   (dmemresp_rdata)
   );

   assign mem.mem_req_type  = req_type_q;
   assign mem.mem_req_addr  = req_addr_q;
   assign mem.mem_req_wdata = req_wdata_q;
   assign err_unexp_resp    = err_unexp_q;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
   assign err_misaligned    = err_mis_q;
`endif

endmodule : proc_dmem_adapter
`default_nettype wire

// File: tb/tb_proc_dmem_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_dmem_adapter
//  Description : Self-checking bench for proc_dmem_adapter. Directed
//                transactions push expected memory requests and load data
//                into queues; a monitor pops and compares them whenever the
//                DUT presents a request or completes a transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_dmem_adapter;
   import proc_dmem_pkg::*;

   typedef struct packed {
      logic        typ;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk;
   logic        rst;
   logic        dmemreq_val;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic [31:0] dmemresp_rdata;
   logic        stall_M;
   logic        err_unexp_resp;
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
   logic        err_misaligned;
`endif

   proc_dmem_adapter_if #(.p_addr_nbits(32), .p_data_nbits(32)) mem_if ();

   proc_dmem_adapter #(.p_addr_nbits(32), .p_data_nbits(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .dmemreq_val    (dmemreq_val),
      .dmemreq_type   (dmemreq_type),
      .dmemreq_addr   (dmemreq_addr),
      .dmemreq_wdata  (dmemreq_wdata),
      .dmemresp_rdata (dmemresp_rdata),
      .stall_M        (stall_M),
      .err_unexp_resp (err_unexp_resp),
`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
      .err_misaligned (err_misaligned),
`endif
      .mem            (mem_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          hs_count = 0;
   req_t        req_q[$];
   logic [31:0] rdata_q[$];
   logic [31:0] model_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: request fields on every REQ cycle, load data in DONE
   // ------------------------------------------------------------------------
   logic waiting   = 1'b0;
   logic done_next = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         waiting   = 1'b0;
         done_next = 1'b0;
      end else begin
         if (done_next) begin
            done_next = 1'b0;
            if (rdata_q.size() == 0) begin
               check("done_unexpected", 32'd1, 32'd0);
            end else begin
               check("done_rdata", dmemresp_rdata, rdata_q.pop_front());
               check("done_stall", {31'd0, stall_M}, 32'd0);
            end
         end
         if (mem_if.mem_req_val) begin
            if (req_q.size() == 0) begin
               check("req_unexpected", 32'd1, 32'd0);
            end else begin
               check("req_type",  {31'd0, mem_if.mem_req_type}, {31'd0, req_q[0].typ});
               check("req_addr",  mem_if.mem_req_addr,  req_q[0].addr);
               check("req_wdata", mem_if.mem_req_wdata, req_q[0].wdata);
               if (mem_if.mem_req_rdy) begin
                  void'(req_q.pop_front());
                  hs_count++;
                  waiting = 1'b1;
               end
            end
         end else if (waiting && mem_if.mem_resp_val) begin
            waiting   = 1'b0;
            done_next = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // One full transaction with rdy_wait REQ stalls and resp_wait WAIT stalls
   // ------------------------------------------------------------------------
   task automatic run_txn(input logic typ, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdy_wait, input int resp_wait);
      int stalls = 0;
      int reqs   = 0;
      req_q.push_back('{typ: typ, addr: addr, wdata: wdata});
      if (typ == DMEM_READ) model_rdata = rdata;
      rdata_q.push_back(model_rdata);
      // IDLE: capture
      @(posedge clk); #1;
      dmemreq_val   = 1'b1;
      dmemreq_type  = typ;
      dmemreq_addr  = addr;
      dmemreq_wdata = wdata;
      mem_if.mem_req_rdy  = 1'b0;
      mem_if.mem_resp_val = 1'b0;
      @(negedge clk);
      if (stall_M) stalls++;
      if (mem_if.mem_req_val) reqs++;
      // REQ: scramble the M-stage inputs to show the captured copy is used
      for (int i = 0; i <= rdy_wait; i++) begin
         @(posedge clk); #1;
         dmemreq_type  = ~typ;
         dmemreq_addr  = ~addr;
         dmemreq_wdata = ~wdata;
         mem_if.mem_req_rdy = (i == rdy_wait);
         @(negedge clk);
         if (stall_M) stalls++;
         if (mem_if.mem_req_val) reqs++;
      end
      // WAIT: junk data before the real response
      for (int i = 0; i <= resp_wait; i++) begin
         @(posedge clk); #1;
         mem_if.mem_req_rdy    = 1'b0;
         mem_if.mem_resp_val   = (i == resp_wait);
         mem_if.mem_resp_rdata = (i == resp_wait) ? rdata : (32'hBAD0_0000 | i);
         @(negedge clk);
         if (stall_M) stalls++;
         if (mem_if.mem_req_val) reqs++;
      end
      // DONE
      @(posedge clk); #1;
      mem_if.mem_resp_val   = 1'b0;
      mem_if.mem_resp_rdata = 32'hFFFF_FFFF;
      dmemreq_val = 1'b0;
      @(negedge clk);
      if (stall_M) stalls++;
      if (mem_if.mem_req_val) reqs++;
      check("txn_stall_cycles", stalls, 3 + rdy_wait + resp_wait);
      check("txn_req_val_cycles", reqs, rdy_wait + 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      dmemreq_val = 1'b0;
      mem_if.mem_req_rdy  = 1'b0;
      mem_if.mem_resp_val = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_rdata = 32'd0;
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int hs0;
      rst = 1'b1;
      dmemreq_val = 1'b0;
      dmemreq_type = DMEM_READ;
      dmemreq_addr = '0;
      dmemreq_wdata = '0;
      mem_if.mem_req_rdy = 1'b0;
      mem_if.mem_resp_val = 1'b0;
      mem_if.mem_resp_rdata = '0;
      model_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_stall", {31'd0, stall_M}, 32'd0);
      check("rst_req_val", {31'd0, mem_if.mem_req_val}, 32'd0);
      check("rst_rdata", dmemresp_rdata, 32'd0);
      check("rst_err_unexp", {31'd0, err_unexp_resp}, 32'd0);
      check("rst_req_addr", mem_if.mem_req_addr, 32'd0);

      // Zero-wait read, write with 3 cycles of backpressure (rdata untouched)
      run_txn(DMEM_READ,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0);
      run_txn(DMEM_WRITE, 32'h0000_2000, 32'h1234_5678, 32'h0BAD_0BAD, 3, 0);
      run_txn(DMEM_READ,  32'h0000_0200, 32'h0,         32'h0000_5A5A, 1, 2);

      // Back-to-back loads: second capture in the IDLE cycle after DONE
      hs0 = hs_count;
      run_txn(DMEM_READ, 32'h0000_0010, 32'h0, 32'h0000_000A, 0, 0);
      run_txn(DMEM_READ, 32'h0000_0014, 32'h0, 32'h0000_000B, 0, 0);
      check("b2b_handshakes", hs_count - hs0, 2);
      check("b2b_err_unexp", {31'd0, err_unexp_resp}, 32'd0);

`ifdef PROC_DMEM_ADAPTER_ALIGN_CHECK_EN
      // Misaligned read completes locally with zero data
      @(posedge clk); #1;
      dmemreq_val = 1'b1; dmemreq_type = DMEM_READ; dmemreq_addr = 32'h0000_0102;
      @(negedge clk);
      check("mis_idle_stall", {31'd0, stall_M}, 32'd1);
      check("mis_idle_req_val", {31'd0, mem_if.mem_req_val}, 32'd0);
      @(posedge clk); #1;
      dmemreq_val = 1'b0;
      @(negedge clk);
      check("mis_done_stall", {31'd0, stall_M}, 32'd0);
      check("mis_done_req_val", {31'd0, mem_if.mem_req_val}, 32'd0);
      check("mis_rdata", dmemresp_rdata, 32'd0);
      check("mis_err", {31'd0, err_misaligned}, 32'd1);
      model_rdata = 32'd0;
`endif

      // Reset while in WAIT, then a late response
      req_q.push_back('{typ: DMEM_READ, addr: 32'h0000_0300, wdata: 32'h0});
      @(posedge clk); #1;
      dmemreq_val = 1'b1; dmemreq_type = DMEM_READ;
      dmemreq_addr = 32'h0000_0300; dmemreq_wdata = 32'h0;
      @(posedge clk); #1;
      mem_if.mem_req_rdy = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_req_rdy = 1'b0;
      dmemreq_val = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("wait_stall_before_rst", {31'd0, stall_M}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      model_rdata = 32'd0;
      @(negedge clk);
      check("postrst_req_val", {31'd0, mem_if.mem_req_val}, 32'd0);
      check("postrst_stall", {31'd0, stall_M}, 32'd0);
      check("postrst_err_unexp", {31'd0, err_unexp_resp}, 32'd0);
      @(posedge clk); #1;
      mem_if.mem_resp_val = 1'b1; mem_if.mem_resp_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_if.mem_resp_val = 1'b0;
      @(negedge clk);
      check("late_resp_err", {31'd0, err_unexp_resp}, 32'd1);
      check("late_resp_rdata", dmemresp_rdata, 32'd0);
      check("late_resp_stall", {31'd0, stall_M}, 32'd0);

      // Spurious response while idle after a fresh reset
      do_reset();
      check("rst2_err_unexp", {31'd0, err_unexp_resp}, 32'd0);
      @(posedge clk); #1;
      mem_if.mem_resp_val = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_resp_val = 1'b0;
      @(negedge clk);
      check("spur_err", {31'd0, err_unexp_resp}, 32'd1);
      check("spur_req_val", {31'd0, mem_if.mem_req_val}, 32'd0);
      check("spur_stall", {31'd0, stall_M}, 32'd0);
      run_txn(DMEM_READ, 32'h0000_0040, 32'h0, 32'h55AA_55AA, 0, 1);
      check("spur_err_sticky", {31'd0, err_unexp_resp}, 32'd1);
      do_reset();
      check("final_err_cleared", {31'd0, err_unexp_resp}, 32'd0);
      check("final_rdata", dmemresp_rdata, 32'd0);

      repeat (2) @(negedge clk);
      check("req_queue_empty", req_q.size(), 32'd0);
      check("rdata_queue_empty", rdata_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_proc_dmem_adapter
`default_nettype wire

// File: doc/proc_dmem_adapter.md
# proc_dmem_adapter

Bridges the TinyRV1 five-stage pipeline's M-stage single-cycle data-memory request to a multi-cycle valid/ready memory port. It sits directly downstream of the processor control unit's M-stage outputs (`dmemreq_val`, `dmemreq_type`) and the datapath's address and write data. It returns load data to the W-stage writeback mux and raises `stall_M`, which the control unit uses to freeze F/D/X/M while a memory transaction is outstanding.

## Interface
Parameters:
- `p_addr_nbits`, 32, width of the memory address.
- `p_data_nbits`, 32, width of read and write data.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `dmemreq_val`  in  1  M-stage request valid. The control unit guarantees 0, never X, when M is invalid.
- `dmemreq_type`  in  1  0 = read (LW), 1 = write (SW).
- `dmemreq_addr`  in  `p_addr_nbits`  byte address.
- `dmemreq_wdata`  in  `p_data_nbits`  store data.
- `dmemresp_rdata`  out  `p_data_nbits`  load data, valid in the DONE cycle.
- `stall_M`  out  1  pipeline hold request to the control unit.
- `mem_req_val`  out  1  memory request valid.
- `mem_req_rdy`  in  1  memory accepts the request.
- `mem_req_type`  out  1  copy of the captured type.
- `mem_req_addr`  out  `p_addr_nbits`  captured address.
- `mem_req_wdata`  out  `p_data_nbits`  captured write data.
- `mem_resp_val`  in  1  memory response valid. The adapter is always ready to take a response.
- `mem_resp_rdata`  in  `p_data_nbits`  response data.
- `err_unexp_resp`  out  1  sticky flag: a response arrived outside WAIT.

## Operation
- FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE
  - If `dmemreq_val`: capture type, addr and wdata into request registers, then go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - `mem_req_val` = 1, driven from the registers.
  - On `mem_req_rdy`: go to WAIT. Otherwise hold; the request fields stay stable.
- WAIT
  - On `mem_resp_val`: if type is read, load `mem_resp_rdata` into the rdata register; go to DONE.
  - A write response's data is discarded, and the rdata register keeps its old value.
- DONE: go to IDLE unconditionally. The pipeline advances in this cycle, so the next `dmemreq_val` belongs to a new instruction.
- `stall_M` = (IDLE & `dmemreq_val`) | REQ | WAIT. It is combinational from state and input, and it is 0 in DONE.
- `dmemresp_rdata` is always driven from the rdata register.
- `mem_resp_val` in IDLE, REQ or DONE:
  - Ignored; no state change.
  - Sets `err_unexp_resp`, which is cleared only by `rst`.
- Reset values:
  - state = IDLE.
  - Request and rdata registers = 0.
  - `mem_req_val` = 0, `stall_M` = 0 (while `dmemreq_val` = 0), `err_unexp_resp` = 0.
- Reset mid-transaction: the cycle after `rst`, the FSM is in IDLE and `mem_req_val` = 0. A late response from the aborted transaction sets `err_unexp_resp`. The memory side must be reset together with the adapter.

## Timing
- Minimum transaction, with `mem_req_rdy` and `mem_resp_val` each high on their first opportunity:
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ, stall.
  - Cycle 2: WAIT, stall.
  - Cycle 3: DONE, no stall, data valid.
- The instruction in M therefore occupies M for 4 cycles.
- Each REQ cycle with `mem_req_rdy` = 0 adds one cycle. Each WAIT cycle with `mem_resp_val` = 0 adds one cycle.
- Back-to-back requests: the next request can be captured in the IDLE cycle that follows DONE.
- At most one request is outstanding. No request is issued in the same cycle it is captured.

## Configuration
- `PROC_DMEM_ADAPTER_ALIGN_CHECK_EN`
- Defined:
  - In IDLE, a request with `dmemreq_addr[1:0]` != 0 goes straight to DONE; `mem_req_val` is never asserted.
  - A read loads 0 into the rdata register.
  - Output `err_misaligned` (1 bit, sticky, reset 0) is set.
  - Stall is 1 cycle (the IDLE cycle only).
- Undefined: `err_misaligned` does not exist, and the address is passed through unchecked.

## Structure
- Package `proc_dmem_pkg` holds:
  - The state enum `dmem_state_t` (IDLE, REQ, WAIT, DONE).
  - Constants `DMEM_READ` = 1'b0 and `DMEM_WRITE` = 1'b1, shared with the control unit.
- The request and rdata registers are instances of the existing `Register` module, each enabled by its capture condition.
- The FSM next-state and output logic are inline. No other sub-module.

## Test plan
- Read, zero wait states: read of 0x100, rdy held 1, resp one cycle after REQ with data 0xDEADBEEF.
  - Required: `stall_M` = 1,1,1,0 over cycles 0-3.
  - `dmemresp_rdata` = 0xDEADBEEF in cycle 3.
  - `mem_req_addr` = 0x100 during REQ.
- Write with backpressure: write of 0x2000 with data 0x12345678, `mem_req_rdy` low for 3 cycles.
  - Required: `mem_req_val` = 1 for 4 cycles with stable addr and data.
  - The rdata register is unchanged.
  - Stall lasts 6 cycles in total.
- Back-to-back loads: 0x10 then 0x14, responses 0xA and 0xB.
  - Required: the second capture happens in the IDLE cycle after DONE.
  - Data is 0xA, then 0xB.
  - Exactly two `mem_req_val` handshakes.
- Reset in WAIT:
  - Required: IDLE the next cycle, `mem_req_val` = 0, `stall_M` = 0.
  - A response arriving afterwards sets `err_unexp_resp` = 1.
- Spurious response while idle: `mem_resp_val` = 1 in IDLE.
  - Required: the state is unchanged and `err_unexp_resp` = 1 and stays set until `rst`.
- With `PROC_DMEM_ADAPTER_ALIGN_CHECK_EN`: read of 0x102.
  - Required: a 1-cycle stall, `mem_req_val` never asserted, `dmemresp_rdata` = 0, `err_misaligned` = 1.
